alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational datapath ALU. It captures operands on a valid/ready handshake and computes single-cycle ops in one clock. Shifts run on an iterative 1-bit-per-cycle shifter. Each result is held with status flags until downstream accepts it. The block sits between operand fetch and writeback in the execute stage, and absorbs downstream stalls without losing data.

---
 rtl/alu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Handshaked execute-stage ALU. A request is captured on i_valid && o_ready.
//   Arithmetic and logic ops complete in one clock. Shifts run on an iterative
//   1-bit-per-cycle shifter. Each result is held with its flags until
//   downstream takes it with i_ready.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_valid     operation request
//   o_ready     idle, request accepted this cycle if i_valid
//   i_operator  opcode (N_BITS_OP)
//   i_data1     operand A / shift source (N_BITS)
//   i_data2     operand B / unsigned shift amount (N_BITS)
//   o_valid     result and flags valid
//   i_ready     downstream accepts result
//   o_result    result (N_BITS)
//   o_zero      result == 0
//   o_neg       result MSB
//   o_carry     carry / borrow / last bit shifted out
//   o_overflow  signed overflow (ADD/SUB only)
//   o_err       unsupported opcode
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter  int N_BITS     = 8,
    parameter  int N_BITS_OP  = 6,
    localparam int N_BITS_CNT = $clog2(N_BITS) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [N_BITS_OP-1:0] i_operator,
    input  logic [N_BITS-1:0]    i_data1,
    input  logic [N_BITS-1:0]    i_data2,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [N_BITS-1:0]    o_result,
    output logic                 o_zero,
    output logic                 o_neg,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_err
);

    localparam logic [N_BITS_OP-1:0] OP_ADD = N_BITS_OP'(6'b100000);
    localparam logic [N_BITS_OP-1:0] OP_SUB = N_BITS_OP'(6'b100010);
    localparam logic [N_BITS_OP-1:0] OP_AND = N_BITS_OP'(6'b100100);
    localparam logic [N_BITS_OP-1:0] OP_OR  = N_BITS_OP'(6'b100101);
    localparam logic [N_BITS_OP-1:0] OP_XOR = N_BITS_OP'(6'b100110);
    localparam logic [N_BITS_OP-1:0] OP_NOR = N_BITS_OP'(6'b100111);
    localparam logic [N_BITS_OP-1:0] OP_SLL = N_BITS_OP'(6'b000000);
    localparam logic [N_BITS_OP-1:0] OP_SRL = N_BITS_OP'(6'b000010);
    localparam logic [N_BITS_OP-1:0] OP_SRA = N_BITS_OP'(6'b000011);

    localparam logic [N_BITS-1:0] WIDTH_VAL = N_BITS'(N_BITS);
    localparam int                MSB       = N_BITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    // Latched request for the iterative shifter.
    logic [N_BITS_OP-1:0]  op_q;
    logic [N_BITS-1:0]     sh_q;
    logic [N_BITS_CNT-1:0] cnt_q;
    logic                  big_q;   // requested amount exceeded N_BITS

    // ---------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the raw inputs at accept time.
    // ---------------------------------------------------------------------
    logic [N_BITS:0]       sum_ext, diff_ext;
    logic [N_BITS-1:0]     res_c;
    logic                  carry_c, ovf_c, err_c, is_shift;
    logic                  amt_big;
    logic [N_BITS-1:0]     amt;
    logic [N_BITS_CNT-1:0] cnt_init;
    logic                  start_shift;

    assign sum_ext  = {1'b0, i_data1} + {1'b0, i_data2};
    assign diff_ext = {1'b0, i_data1} - {1'b0, i_data2};

    assign amt_big     = i_data2 > WIDTH_VAL;
    assign amt         = amt_big ? WIDTH_VAL : i_data2;
    assign cnt_init    = N_BITS_CNT'(amt);
    assign start_shift = is_shift && (amt != '0);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        res_c    = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        err_c    = 1'b0;
        is_shift = 1'b0;
        case (i_operator)
            OP_ADD: begin
                res_c   = sum_ext[N_BITS-1:0];
                carry_c = sum_ext[N_BITS];
                ovf_c   = (i_data1[MSB] == i_data2[MSB]) && (res_c[MSB] != i_data1[MSB]);
            end
            OP_SUB: begin
                res_c   = diff_ext[N_BITS-1:0];
                carry_c = diff_ext[N_BITS];   // borrow out of the top bit
                ovf_c   = (i_data1[MSB] != i_data2[MSB]) && (res_c[MSB] != i_data1[MSB]);
            end
            OP_AND: res_c = i_data1 & i_data2;
            OP_OR:  res_c = i_data1 | i_data2;
            OP_XOR: res_c = i_data1 ^ i_data2;
            OP_NOR: res_c = ~(i_data1 | i_data2);
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                res_c    = i_data1;           // shift by zero passes A through
            end
            default: err_c = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------
    // One step of the iterative shifter.
    // ---------------------------------------------------------------------
    logic [N_BITS-1:0] sh_next;
    logic              sh_out;
    logic              fill_bit;
    logic              last_carry;

    always_comb begin
        sh_next  = sh_q;
        sh_out   = 1'b0;
        fill_bit = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_next = {sh_q[N_BITS-2:0], 1'b0};
                sh_out  = sh_q[MSB];
            end
            OP_SRL: begin
                sh_next = {1'b0, sh_q[N_BITS-1:1]};
                sh_out  = sh_q[0];
            end
            OP_SRA: begin
                sh_next  = {sh_q[MSB], sh_q[N_BITS-1:1]};
                sh_out   = sh_q[0];
                fill_bit = sh_q[MSB];
            end
            default: ;
        endcase
    end

    // An amount beyond the width shifts out a fill bit last, not an A bit.
    assign last_carry = big_q ? fill_bit : sh_out;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = start_shift ? SHIFT : DONE;
            SHIFT:   if (cnt_q == N_BITS_CNT'(1)) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            big_q      <= 1'b0;
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_neg      <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q  <= i_operator;
                        sh_q  <= i_data1;
                        cnt_q <= cnt_init;
                        big_q <= amt_big;
                        // Shifts with k>0 publish their result only on DONE entry.
                        if (!start_shift) begin
                            o_result   <= res_c;
                            o_zero     <= (res_c == '0);
                            o_neg      <= res_c[MSB];
                            o_carry    <= carry_c;
                            o_overflow <= ovf_c;
                            o_err      <= err_c;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - N_BITS_CNT'(1);
                    if (cnt_q == N_BITS_CNT'(1)) begin
                        o_result   <= sh_next;
                        o_zero     <= (sh_next == '0);
                        o_neg      <= sh_next[MSB];
                        o_carry    <= last_carry;
                        o_overflow <= 1'b0;
                        o_err      <= 1'b0;
                    end
                end
                default: ;   // DONE holds result and flags
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq (N_BITS=8). Directed cases followed by
//   randomized requests, each compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int N = 8;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [5:0] i_operator;
    logic [7:0] i_data1;
    logic [7:0] i_data2;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_neg;
    logic       o_carry;
    logic       o_overflow;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // Expected values of the result currently held in DONE.
    logic [7:0] exp_res;
    logic       exp_c, exp_v, exp_e;

    alu_seq #(.N_BITS(8), .N_BITS_OP(6)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_operator (i_operator),
        .i_data1    (i_data1),
        .i_data2    (i_data2),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_neg      (o_neg),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: results from the opcode rules with plain integer math.
    task automatic model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic c, output logic v,
                         output logic e, output int lat);
        int ua, ub, sa, sb, r, k;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        k   = (ub > N) ? N : ub;
        r   = 0;
        c   = 1'b0;
        v   = 1'b0;
        e   = 1'b0;
        lat = 1;
        case (op)
            6'b100000: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            6'b100010: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            6'b100100: r = ua & ub;
            6'b100101: r = ua | ub;
            6'b100110: r = ua ^ ub;
            6'b100111: r = ~(ua | ub);
            6'b000000: begin
                r   = ua << k;
                c   = (ub == 0 || ub > N) ? 1'b0 : (((ua >> (N - ub)) & 1) != 0);
                lat = 1 + k;
            end
            6'b000010: begin
                r   = ua >> k;
                c   = (ub == 0) ? 1'b0 : (((ua >> (ub - 1)) & 1) != 0);
                lat = 1 + k;
            end
            6'b000011: begin
                r   = sa >>> k;
                c   = (ub == 0) ? 1'b0 : (((sa >>> (ub - 1)) & 1) != 0);
                lat = 1 + k;
            end
            default: e = 1'b1;
        endcase
        res = 8'(r);
    endtask

    // Present a request; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        check("ready_before_issue", o_ready, 1);
        i_valid    = 1'b1;
        i_operator = op;
        i_data1    = a;
        i_data2    = b;
        @(negedge i_clk);
        // Busy now: inputs are noise that must be ignored.
        i_valid    = 1'($urandom_range(0, 1));
        i_operator = 6'($urandom);
        i_data1    = 8'($urandom);
        i_data2    = 8'($urandom);
    endtask

    // Called one negedge after the accept edge; waits for o_valid and checks.
    task automatic await_check(input string tag, input logic [5:0] op,
                               input logic [7:0] a, input logic [7:0] b);
        int exp_lat, lat;
        model(op, a, b, exp_res, exp_c, exp_v, exp_e, exp_lat);
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        check({tag, "_valid"},    o_valid,    1);
        check({tag, "_latency"},  lat,        exp_lat);
        check({tag, "_result"},   o_result,   exp_res);
        check({tag, "_zero"},     o_zero,     (exp_res == 8'h00));
        check({tag, "_neg"},      o_neg,      exp_res[7]);
        check({tag, "_carry"},    o_carry,    exp_c);
        check({tag, "_overflow"}, o_overflow, exp_v);
        check({tag, "_err"},      o_err,      exp_e);
    endtask

    // Stall for some cycles, then complete the result handshake.
    task automatic retire(input int stall);
        for (int i = 0; i < stall; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            check("stall_valid",  o_valid,  1);
            check("stall_ready",  o_ready,  0);
            check("stall_result", o_result, exp_res);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("retire_valid", o_valid, 0);
        check("retire_ready", o_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int stall);
        issue(op, a, b);
        await_check(tag, op, a, b);
        retire(stall);
    endtask

    logic [5:0] op_list [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                 6'b100111, 6'b000000, 6'b000010, 6'b000011, 6'b010101};

    initial begin
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_operator = '0;
        i_data1    = '0;
        i_data2    = '0;
        repeat (2) @(negedge i_clk);
        check("rst_ready",  o_ready,  1);
        check("rst_valid",  o_valid,  0);
        check("rst_result", o_result, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Reset in the middle of a shift aborts it.
        issue(6'b000010, 8'h80, 8'd5);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("midshift_ready", o_ready, 0);
        check("midshift_valid", o_valid, 0);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        check("abort_ready",  o_ready,  1);
        check("abort_valid",  o_valid,  0);
        check("abort_result", o_result, 0);
        check("abort_flags",  {o_zero, o_neg, o_carry, o_overflow, o_err}, 0);
        @(negedge i_clk);
        check("abort_idle", o_valid, 0);

        // Directed cases.
        run_op("add_ovf",   6'b100000, 8'h7F, 8'h01, 0);
        run_op("add_wrap",  6'b100000, 8'hFF, 8'h01, 1);
        run_op("sub_borr",  6'b100010, 8'h05, 8'h07, 0);
        run_op("nor_zero",  6'b100111, 8'h0F, 8'hF0, 0);
        run_op("srl3",      6'b000010, 8'h80, 8'd3,  0);
        run_op("sra3",      6'b000011, 8'h80, 8'd3,  0);
        run_op("sll1",      6'b000000, 8'h81, 8'd1,  2);
        run_op("sll0",      6'b000000, 8'hA5, 8'd0,  0);
        run_op("sra0",      6'b000011, 8'h81, 8'd0,  0);
        run_op("sra9",      6'b000011, 8'h80, 8'd9,  0);
        run_op("srl200",    6'b000010, 8'h80, 8'd200, 0);
        run_op("sll8",      6'b000000, 8'h01, 8'd8,  0);
        run_op("srl8",      6'b000010, 8'h80, 8'd8,  0);

        // Backpressure: new request held on the inputs throughout the stall.
        issue(6'b100000, 8'h12, 8'h34);
        await_check("bp_add", 6'b100000, 8'h12, 8'h34);
        i_valid    = 1'b1;
        i_operator = 6'b111111;
        i_data1    = 8'h5A;
        i_data2    = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_valid",  o_valid,  1);
            check("bp_ready",  o_ready,  0);
            check("bp_result", o_result, 8'h46);
            check("bp_flags",  {o_zero, o_neg, o_carry, o_overflow, o_err}, 0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("bp_release_valid", o_valid, 0);
        check("bp_release_ready", o_ready, 1);
        @(negedge i_clk);            // held request accepted on this edge
        i_valid = 1'b0;
        await_check("bad_op", 6'b111111, 8'h5A, 8'hC3);
        retire(0);

        // Randomized requests.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [7:0] a, b;
            op = op_list[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            run_op("rand", op, a, b, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
